mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single SRAM-like memory port between the fetch-stage instruction requester (I) and the mem-stage data requester (D).
- Allows one outstanding transaction at a time. D has priority, with a starvation guard for I.
- Supports dropping an in-flight fetch when fetch is flushed (branch or exception redirect).
- Its addr_ok/data_ok returns drive the stall inputs of the pipeline hazard logic.

Parameters:
- AW, 32, address width
- DW, 32, data width
- I_STARVE_MAX, 8, number of consecutive D grants made while i_req was pending, after which I is forced the next grant; range 1..255

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- i_req  in  1  instruction read request; held until i_addr_ok
- i_addr  in  AW  instruction address; stable while i_req is high
- i_flush  in  1  discard the current or just-granted instruction transaction
- i_addr_ok  out  1  instruction address accepted (1-cycle pulse)
- i_data_ok  out  1  instruction data valid (1-cycle pulse)
- i_rdata  out  DW  instruction read data; valid when i_data_ok is high
- d_req  in  1  data request; held until d_addr_ok
- d_wr  in  1  1 = write
- d_size  in  2  0 = byte, 1 = half, 2 = word
- d_addr  in  AW  data address
- d_wdata  in  DW  write data
- d_addr_ok  out  1  data address accepted (pulse)
- d_data_ok  out  1  data read or write complete (pulse)
- d_rdata  out  DW  data read data
- bus_req  out  1  memory request
- bus_wr  out  1  memory write
- bus_size  out  2  memory size
- bus_addr  out  AW  memory address
- bus_wdata  out  DW  memory write data
- bus_addr_ok  in  1  memory accepted request
- bus_data_ok  in  1  memory returned or completed
- bus_rdata  in  DW  memory read data
- busy  out  1  state is not IDLE

Behaviour:
- Reset (resetn=0, asynchronous): state=IDLE, owner=I, drop=0, starve_cnt=0. All bus_* registers and all outputs are 0.
- States: IDLE, ADDR, DATA.
- IDLE, arbitration (one decision per cycle):
  - d_req=1 and (i_req=0 or starve_cnt<I_STARVE_MAX): grant D.
  - Otherwise, if i_req=1: grant I.
  - Otherwise stay in IDLE.
- On grant:
  - owner is registered; bus_addr, bus_wr, bus_size and bus_wdata are latched from the winner.
  - For an I grant, bus_wr=0 and bus_size=2.
  - Next state is ADDR.
  - Latency: request to bus_req is 1 cycle.
- starve_cnt:
  - Increments, saturating at 255, on each D grant made while i_req=1.
  - Clears on any I grant, and on any IDLE cycle with i_req=0.
- ADDR:
  - bus_req=1; the bus_* outputs are held stable.
  - When bus_addr_ok=1: the owner's *_addr_ok pulses combinationally in the same cycle, bus_req deasserts from the next cycle, and next state is DATA.
- DATA:
  - bus_req=0.
  - When bus_data_ok=1: the owner's *_data_ok pulses in the same cycle and the owner's *_rdata = bus_rdata. Next state is IDLE.
  - Minimum spacing between transactions: the grant is not made before the IDLE cycle after completion. Minimum period is 3 cycles.
- *_rdata: the non-owner's rdata output is 0.
- A bus_addr_ok or bus_data_ok arriving in a state where it is not expected is ignored. Neither requester sees a pulse.
- i_flush:
  - If owner=I and state is ADDR or DATA, set drop=1.
  - If an I grant happens in the same IDLE cycle as i_flush, drop is set on that grant.
  - With drop=1, i_addr_ok and i_data_ok are suppressed for that transaction. The bus transaction still completes, because bus_req is never withdrawn once raised.
  - drop clears on entry to IDLE.
  - i_flush while owner=D, or while IDLE with no I grant: no effect.
- Simultaneous bus_addr_ok and bus_data_ok in ADDR: only addr_ok is acted on. The bus guarantees data_ok comes at least 1 cycle after addr_ok.
- Requests that are not granted are not latched. Requesters must hold req and fields stable until addr_ok.
- Reset mid-transaction: everything returns to reset values immediately and the outstanding bus transaction is abandoned. The memory model is reset by the same resetn.

Test Plan:
- Single I fetch: i_req=1, i_addr=0xBFC00000, memory addr_ok at +1, data_ok at +2 with rdata=0x3C011234. Required: bus_req in cycle 1, i_addr_ok in cycle 2, i_data_ok with i_rdata=0x3C011234 in cycle 3, busy=0 in cycle 4.
- Conflict: i_req=1 and d_req=1 (d_wr=1, d_addr=0x80000010, d_wdata=0xDEADBEEF, d_size=2) in the same cycle. Required: D is granted first with bus_wr=1 and bus_addr=0x80000010; I is granted on the next IDLE cycle.
- Starvation with I_STARVE_MAX=2: d_req and i_req held continuously. Required grant order is D, D, I, D, D, I; starve_cnt reads 0 after each I grant.
- Flush in flight: I granted, i_flush=1 in the DATA state. Required: i_data_ok stays 0 when bus_data_ok arrives, the state returns to IDLE, and the following fetch completes normally with i_data_ok.
- Flush at grant: i_flush=1 in the same cycle as an I grant. Required: neither i_addr_ok nor i_data_ok pulses, and bus_req still asserts in ADDR.
- Async reset: resetn=0 mid-DATA. Required: busy, bus_req, all ok pulses and all bus_* outputs are 0 within the same cycle, without waiting for a clock edge.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if
// Groups the three sides that meet at the arbiter: the instruction requester
// (i_*), the data requester (d_*), and the single SRAM-like memory port (bus_*).
//   i_req/i_addr/i_flush            -> arbiter   fetch request and redirect flush
//   i_addr_ok/i_data_ok/i_rdata     <- arbiter   fetch handshake returns
//   d_req/d_wr/d_size/d_addr/d_wdata-> arbiter   load/store request
//   d_addr_ok/d_data_ok/d_rdata     <- arbiter   load/store handshake returns
//   bus_req/bus_wr/bus_size/bus_addr/bus_wdata <- arbiter   memory request
//   bus_addr_ok/bus_data_ok/bus_rdata          -> arbiter   memory responses
//   busy                            <- arbiter   a transaction is in flight
// Modport slave is the arbiter's view (it serves the requesters and owns the
// bus request); modport master is the surrounding pipeline + memory view.
interface mem_bus_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_flush;
  logic          i_addr_ok;
  logic          i_data_ok;
  logic [DW-1:0] i_rdata;

  logic          d_req;
  logic          d_wr;
  logic [1:0]    d_size;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_addr_ok;
  logic          d_data_ok;
  logic [DW-1:0] d_rdata;

  logic          bus_req;
  logic          bus_wr;
  logic [1:0]    bus_size;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_addr_ok;
  logic          bus_data_ok;
  logic [DW-1:0] bus_rdata;

  logic          busy;

  modport slave (
    input  i_req, i_addr, i_flush,
    output i_addr_ok, i_data_ok, i_rdata,
    input  d_req, d_wr, d_size, d_addr, d_wdata,
    output d_addr_ok, d_data_ok, d_rdata,
    output bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
    input  bus_addr_ok, bus_data_ok, bus_rdata,
    output busy
  );

  modport master (
    output i_req, i_addr, i_flush,
    input  i_addr_ok, i_data_ok, i_rdata,
    output d_req, d_wr, d_size, d_addr, d_wdata,
    input  d_addr_ok, d_data_ok, d_rdata,
    input  bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
    output bus_addr_ok, bus_data_ok, bus_rdata,
    input  busy
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares one SRAM-like memory port between the fetch (I) and mem-stage (D)
// requesters, one outstanding transaction at a time. D wins ties unless I has
// been passed over I_STARVE_MAX times in a row. A fetch flush drops the
// handshake returns of an in-flight fetch while the bus transaction itself
// still runs to completion.
// Ports:
//   clk    rising-edge clock
//   resetn asynchronous active-low reset
//   mbus   requester and memory signals (see mem_bus_arbiter_if)
//
// state | meaning
// IDLE  | no transaction; arbitrate and latch the winner's request
// ADDR  | bus_req high, waiting for bus_addr_ok
// DATA  | address accepted, waiting for bus_data_ok
module mem_bus_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int I_STARVE_MAX = 8
) (
  input logic             clk,
  input logic             resetn,
  mem_bus_arbiter_if.slave mbus
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  localparam logic [7:0] STARVE_MAX = 8'(I_STARVE_MAX);

  state_t        state, stateNext;
  logic          ownerD;
  logic          drop;
  logic [7:0]    starveCnt;
  logic          busWr;
  logic [1:0]    busSize;
  logic [AW-1:0] busAddr;
  logic [DW-1:0] busWdata;

  logic grantD, grantI;
  logic addrPhaseOk, dataPhaseOk;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    grantD    = 1'b0;
    grantI    = 1'b0;
    unique case (state)
      IDLE: begin
        if (mbus.d_req && (!mbus.i_req || starveCnt < STARVE_MAX)) begin
          grantD    = 1'b1;
          stateNext = ADDR;
        end else if (mbus.i_req) begin
          grantI    = 1'b1;
          stateNext = ADDR;
        end
      end
      ADDR:    if (mbus.bus_addr_ok) stateNext = DATA;
      DATA:    if (mbus.bus_data_ok) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ownerD    <= 1'b0;
      drop      <= 1'b0;
      starveCnt <= '0;
      busWr     <= 1'b0;
      busSize   <= '0;
      busAddr   <= '0;
      busWdata  <= '0;
    end else begin
      if (grantD) begin
        ownerD   <= 1'b1;
        busWr    <= mbus.d_wr;
        busSize  <= mbus.d_size;
        busAddr  <= mbus.d_addr;
        busWdata <= mbus.d_wdata;
      end else if (grantI) begin
        ownerD   <= 1'b0;
        busWr    <= 1'b0;
        busSize  <= 2'd2;
        busAddr  <= mbus.i_addr;
        busWdata <= '0;
      end

      // Counts D wins that bypassed a waiting I; any IDLE cycle without an
      // I request means I was not actually starved, so the count restarts.
      if (grantI)
        starveCnt <= '0;
      else if (grantD && mbus.i_req)
        starveCnt <= (starveCnt == 8'hFF) ? starveCnt : starveCnt + 8'd1;
      else if (state == IDLE && !mbus.i_req)
        starveCnt <= '0;

      // Returning to IDLE closes the transaction, so it overrides a flush
      // seen in the same final cycle.
      if (dataPhaseOk)
        drop <= 1'b0;
      else if (grantI)
        drop <= mbus.i_flush;
      else if (state != IDLE && !ownerD && mbus.i_flush)
        drop <= 1'b1;
    end
  end

  // Responses outside their expected state never reach a requester.
  assign addrPhaseOk = (state == ADDR) && mbus.bus_addr_ok;
  assign dataPhaseOk = (state == DATA) && mbus.bus_data_ok;

  assign mbus.i_addr_ok = addrPhaseOk && !ownerD && !drop;
  assign mbus.d_addr_ok = addrPhaseOk &&  ownerD;
  assign mbus.i_data_ok = dataPhaseOk && !ownerD && !drop;
  assign mbus.d_data_ok = dataPhaseOk &&  ownerD;
  assign mbus.i_rdata   = mbus.i_data_ok ? mbus.bus_rdata : '0;
  assign mbus.d_rdata   = mbus.d_data_ok ? mbus.bus_rdata : '0;

  assign mbus.bus_req   = (state == ADDR);
  assign mbus.bus_wr    = busWr;
  assign mbus.bus_size  = busSize;
  assign mbus.bus_addr  = busAddr;
  assign mbus.bus_wdata = busWdata;
  assign mbus.busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;
  localparam int STARVE = 2;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.AW(32), .DW(32)) mif();

  mem_bus_arbiter #(.AW(32), .DW(32), .I_STARVE_MAX(STARVE)) dut (
    .clk    (clk),
    .resetn (resetn),
    .mbus   (mif)
  );

  int nTests = 0;
  int nFail  = 0;

  // Transaction-level model: at most one record in flight.
  bit          mActive, mAccepted, mWhoD, mDropped;
  bit          mWr;
  logic [1:0]  mSize;
  logic [31:0] mAddr, mWdata;
  int          mStarve;

  // Model outcomes of the last compared cycle, used by the requester agents.
  bit lastIAddrOk, lastDAddrOk;

  // DUT samples of the last compared cycle, for literal expectations.
  logic        sBusReq, sBusy, sIAddrOk, sIDataOk, sDAddrOk, sDDataOk, sBusWr;
  logic [1:0]  sBusSize;
  logic [31:0] sBusAddr, sIRdata;
  logic [7:0]  sStarve;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mActive = 0; mAccepted = 0; mWhoD = 0; mDropped = 0;
    mWr = 0; mSize = '0; mAddr = '0; mWdata = '0; mStarve = 0;
    lastIAddrOk = 0; lastDAddrOk = 0;
  endtask

  task automatic clearInputs();
    mif.i_req = 0; mif.i_addr = '0; mif.i_flush = 0;
    mif.d_req = 0; mif.d_wr = 0; mif.d_size = '0; mif.d_addr = '0; mif.d_wdata = '0;
    mif.bus_addr_ok = 0; mif.bus_data_ok = 0; mif.bus_rdata = '0;
  endtask

  // Called just after a falling edge with this cycle's inputs applied.
  task automatic step();
    bit eIAO, eDAO, eIDO, eDDO;
    #1;
    eIAO = mActive && !mAccepted && !mWhoD && mif.bus_addr_ok && !mDropped;
    eDAO = mActive && !mAccepted &&  mWhoD && mif.bus_addr_ok;
    eIDO = mActive &&  mAccepted && !mWhoD && mif.bus_data_ok && !mDropped;
    eDDO = mActive &&  mAccepted &&  mWhoD && mif.bus_data_ok;

    chk("busy",       mif.busy,      mActive);
    chk("bus_req",    mif.bus_req,   mActive && !mAccepted);
    chk("bus_wr",     mif.bus_wr,    mWr);
    chk("bus_size",   mif.bus_size,  mSize);
    chk("bus_addr",   mif.bus_addr,  mAddr);
    chk("bus_wdata",  mif.bus_wdata, mWdata);
    chk("i_addr_ok",  mif.i_addr_ok, eIAO);
    chk("d_addr_ok",  mif.d_addr_ok, eDAO);
    chk("i_data_ok",  mif.i_data_ok, eIDO);
    chk("d_data_ok",  mif.d_data_ok, eDDO);
    chk("i_rdata",    mif.i_rdata,   eIDO ? mif.bus_rdata : 32'h0);
    chk("d_rdata",    mif.d_rdata,   eDDO ? mif.bus_rdata : 32'h0);
    chk("starve_cnt", dut.starveCnt, mStarve);

    sBusReq = mif.bus_req; sBusy = mif.busy; sBusWr = mif.bus_wr;
    sBusSize = mif.bus_size; sBusAddr = mif.bus_addr;
    sIAddrOk = mif.i_addr_ok; sIDataOk = mif.i_data_ok; sIRdata = mif.i_rdata;
    sDAddrOk = mif.d_addr_ok; sDDataOk = mif.d_data_ok; sStarve = dut.starveCnt;
    lastIAddrOk = eIAO; lastDAddrOk = eDAO;

    if (!mActive) begin
      if (mif.d_req && (!mif.i_req || mStarve < STARVE)) begin
        mActive = 1; mAccepted = 0; mWhoD = 1; mDropped = 0;
        mWr = mif.d_wr; mSize = mif.d_size; mAddr = mif.d_addr; mWdata = mif.d_wdata;
        mStarve = mif.i_req ? ((mStarve >= 255) ? 255 : mStarve + 1) : 0;
      end else if (mif.i_req) begin
        mActive = 1; mAccepted = 0; mWhoD = 0; mDropped = mif.i_flush;
        mWr = 0; mSize = 2'd2; mAddr = mif.i_addr; mWdata = '0;
        mStarve = 0;
      end else begin
        mStarve = 0;
      end
    end else begin
      if (!mWhoD && mif.i_flush) mDropped = 1;
      if (!mAccepted) begin
        if (mif.bus_addr_ok) mAccepted = 1;
      end else if (mif.bus_data_ok) begin
        mActive = 0; mDropped = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    resetn = 0;
    clearInputs();
    modelReset();
    #2;
    resetn = 1;
  endtask

  initial begin
    string order;
    bit iPend, dPend, lastFlush;

    resetn = 0;
    clearInputs();
    modelReset();

    // Single fetch with exact cycle positions.
    doReset();
    mif.i_req = 1; mif.i_addr = 32'hBFC00000;
    step(); chk("t1_c0_bus_req", sBusReq, 1'b0);
    step(); chk("t1_c1_bus_req", sBusReq, 1'b1); chk("t1_c1_i_addr_ok", sIAddrOk, 1'b0);
    mif.bus_addr_ok = 1;
    step(); chk("t1_c2_i_addr_ok", sIAddrOk, 1'b1); chk("t1_c2_bus_addr", sBusAddr, 32'hBFC00000);
    chk("t1_c2_bus_size", sBusSize, 2'd2);
    mif.i_req = 0; mif.bus_addr_ok = 0; mif.bus_data_ok = 1; mif.bus_rdata = 32'h3C011234;
    step(); chk("t1_c3_i_data_ok", sIDataOk, 1'b1); chk("t1_c3_i_rdata", sIRdata, 32'h3C011234);
    mif.bus_data_ok = 0;
    step(); chk("t1_c4_busy", sBusy, 1'b0);

    // Conflict: D first, then I on the next IDLE cycle.
    doReset();
    mif.i_req = 1; mif.i_addr = 32'hBFC00004;
    mif.d_req = 1; mif.d_wr = 1; mif.d_addr = 32'h80000010; mif.d_wdata = 32'hDEADBEEF; mif.d_size = 2'd2;
    step();
    mif.bus_addr_ok = 1;
    step(); chk("t2_bus_wr", sBusWr, 1'b1); chk("t2_bus_addr_d", sBusAddr, 32'h80000010);
    chk("t2_d_addr_ok", sDAddrOk, 1'b1); chk("t2_i_addr_ok_lo", sIAddrOk, 1'b0);
    mif.d_req = 0; mif.bus_addr_ok = 0; mif.bus_data_ok = 1;
    step(); chk("t2_d_data_ok", sDDataOk, 1'b1);
    mif.bus_data_ok = 0;
    step(); chk("t2_idle_busy", sBusy, 1'b0);
    mif.bus_addr_ok = 1;
    step(); chk("t2_i_addr_ok", sIAddrOk, 1'b1); chk("t2_bus_addr_i", sBusAddr, 32'hBFC00004);
    chk("t2_bus_wr_i", sBusWr, 1'b0);
    mif.i_req = 0; mif.bus_addr_ok = 0; mif.bus_data_ok = 1;
    step();
    mif.bus_data_ok = 0;
    step();

    // Starvation guard with both requests held continuously.
    doReset();
    mif.i_req = 1; mif.i_addr = 32'hBFC00200;
    mif.d_req = 1; mif.d_wr = 0; mif.d_addr = 32'h80000100; mif.d_size = 2'd1;
    mif.bus_addr_ok = 1; mif.bus_data_ok = 1;
    order = "";
    for (int c = 0; c < 18; c++) begin
      step();
      if (sDAddrOk) order = {order, "D"};
      if (sIAddrOk) begin
        order = {order, "I"};
        chk("t3_starve_after_i", sStarve, 8'd0);
      end
    end
    nTests++;
    if (order != "DDIDDI") begin
      nFail++;
      $display("FAIL t3_grant_order: got %s expected DDIDDI", order);
    end
    clearInputs();
    step();

    // Flush while the fetch is in DATA.
    doReset();
    mif.i_req = 1; mif.i_addr = 32'hBFC00100;
    step();
    mif.bus_addr_ok = 1;
    step(); chk("t4_i_addr_ok", sIAddrOk, 1'b1);
    mif.i_req = 0; mif.bus_addr_ok = 0; mif.i_flush = 1;
    step();
    mif.i_flush = 0; mif.bus_data_ok = 1; mif.bus_rdata = 32'h11111111;
    step(); chk("t4_i_data_ok_dropped", sIDataOk, 1'b0); chk("t4_i_rdata_dropped", sIRdata, 32'h0);
    mif.bus_data_ok = 0;
    step(); chk("t4_busy_idle", sBusy, 1'b0);
    mif.i_req = 1; mif.i_addr = 32'hBFC00104;
    step();
    mif.bus_addr_ok = 1;
    step();
    mif.i_req = 0; mif.bus_addr_ok = 0; mif.bus_data_ok = 1; mif.bus_rdata = 32'h22222222;
    step(); chk("t4_next_i_data_ok", sIDataOk, 1'b1); chk("t4_next_i_rdata", sIRdata, 32'h22222222);
    mif.bus_data_ok = 0;
    step();

    // Flush in the same cycle as the I grant.
    doReset();
    mif.i_req = 1; mif.i_addr = 32'hBFC00300; mif.i_flush = 1;
    step();
    mif.i_req = 0; mif.i_flush = 0; mif.bus_addr_ok = 1;
    step(); chk("t5_bus_req", sBusReq, 1'b1); chk("t5_i_addr_ok", sIAddrOk, 1'b0);
    mif.bus_addr_ok = 0; mif.bus_data_ok = 1; mif.bus_rdata = 32'h33333333;
    step(); chk("t5_i_data_ok", sIDataOk, 1'b0);
    mif.bus_data_ok = 0;
    step(); chk("t5_busy", sBusy, 1'b0);

    // Asynchronous reset in the middle of DATA.
    doReset();
    mif.i_req = 1; mif.i_addr = 32'hBFC00400;
    step();
    mif.bus_addr_ok = 1;
    step();
    mif.i_req = 0; mif.bus_addr_ok = 0;
    step();
    mif.bus_data_ok = 1; mif.bus_addr_ok = 1; mif.bus_rdata = 32'h44444444;
    #2;
    chk("t6_busy_before", mif.busy, 1'b1);
    chk("t6_i_data_ok_before", mif.i_data_ok, 1'b1);
    resetn = 0;
    #1;
    chk("t6_busy", mif.busy, 1'b0);
    chk("t6_bus_req", mif.bus_req, 1'b0);
    chk("t6_i_data_ok", mif.i_data_ok, 1'b0);
    chk("t6_d_data_ok", mif.d_data_ok, 1'b0);
    chk("t6_i_addr_ok", mif.i_addr_ok, 1'b0);
    chk("t6_d_addr_ok", mif.d_addr_ok, 1'b0);
    chk("t6_i_rdata", mif.i_rdata, 32'h0);
    chk("t6_bus_addr", mif.bus_addr, 32'h0);
    chk("t6_bus_size", mif.bus_size, 2'd0);
    chk("t6_bus_wr", mif.bus_wr, 1'b0);
    chk("t6_bus_wdata", mif.bus_wdata, 32'h0);
    clearInputs();
    modelReset();
    @(negedge clk);
    resetn = 1;

    // Randomized traffic with spurious bus responses and random flushes.
    iPend = 0; dPend = 0; lastFlush = 0;
    for (int c = 0; c < 4000; c++) begin
      if (lastIAddrOk || lastFlush) iPend = 0;
      if (!iPend && $urandom_range(0, 1) == 1) begin
        iPend = 1;
        mif.i_addr = $urandom;
      end
      mif.i_req = iPend;
      mif.i_flush = ($urandom_range(0, 9) == 0);
      lastFlush = mif.i_flush;

      if (lastDAddrOk) dPend = 0;
      if (!dPend && $urandom_range(0, 2) != 0) begin
        dPend = 1;
        mif.d_wr = 1'($urandom_range(0, 1));
        mif.d_size = 2'($urandom_range(0, 2));
        mif.d_addr = $urandom;
        mif.d_wdata = $urandom;
      end
      mif.d_req = dPend;

      mif.bus_addr_ok = ($urandom_range(0, 2) == 0);
      mif.bus_data_ok = ($urandom_range(0, 2) == 0);
      mif.bus_rdata = $urandom;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
